// File: rtl/ip_codma_pkg.sv
// Shared definitions for the CODMA memory target: size encodings, FSM states
// and the size-to-beat-count decode.
package ip_codma_pkg;

    localparam logic [3:0] SIZE_1DW = 4'd1;
    localparam logic [3:0] SIZE_2DW = 4'd2;
    localparam logic [3:0] SIZE_4DW = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RWAIT,
        ST_RDATA,
        ST_WDATA,
        ST_ERR
    } mem_target_state_t;

    // Zero marks an illegal size encoding.
    function automatic logic [2:0] size_to_beats(input logic [3:0] size);
        case (size)
            SIZE_1DW: return 3'd1;
            SIZE_2DW: return 3'd2;
            SIZE_4DW: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ip_codma_mem_array.sv
// DEPTH x 64-bit storage: combinational read port, synchronous write port,
// contents are never reset.
module ip_codma_mem_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [63:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ip_codma_mem_target.sv
// CODMA memory-bus slave: address phase with grant/error, burst reads with a
// fixed initial wait, and burst writes that tolerate gaps in write_valid.
module ip_codma_mem_target
    import ip_codma_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_WAIT   = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       addr,
    input  logic [3:0]        size,
    output logic              grant,
    output logic [63:0]       read_data,
    output logic              read_valid,
    input  logic [63:0]       write_data,
    input  logic              write_valid,
    output logic              error,
    output mem_target_state_t dbg_state
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam bit HAS_WAIT = (RD_WAIT > 0);

    // Handshake: the master holds read/write/addr/size until it sees the
    // one-cycle grant; only the IDLE state samples them. After grant the
    // slave owns the data phase: read_valid beats are back-to-back with no
    // back-pressure, and each write_valid cycle in WDATA consumes one beat.

    mem_target_state_t state, state_nxt;

    logic             cap_read;
    logic             cap_legal;
    logic [IDX_W-1:0] cap_idx;
    logic [1:0]       cap_last;
    logic [1:0]       beat;
    logic [2:0]       wait_cnt;

    logic             mem_we;
    logic             beat_inc;
    logic [IDX_W-1:0] mem_idx;
    logic [63:0]      mem_rdata;

    // Legality is evaluated on the raw request so it can be captured in IDLE.
    // The word offset carries a borrow bit; the end-of-burst compare is 33 bits
    // wide so no address near the top of the space can wrap into range.
    logic [2:0]  req_beats;
    logic [29:0] word_off;
    logic [32:0] end_word;
    logic        req_legal;

    assign req_beats = size_to_beats(size);
    assign word_off  = {1'b0, addr[31:3]} - {1'b0, BASE_ADDR[31:3]};
    assign end_word  = {4'b0, word_off[28:0]} + {30'b0, req_beats};
    assign req_legal = (read ^ write) && (req_beats != 3'd0) &&
                       (addr[2:0] == 3'b000) && !word_off[29] &&
                       (end_word <= 33'(DEPTH));

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        read_valid = 1'b0;
        error      = 1'b0;
        mem_we     = 1'b0;
        beat_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (read | write) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                grant = 1'b1;
                if (!cap_legal)     state_nxt = ST_ERR;
                else if (!cap_read) state_nxt = ST_WDATA;
                else if (HAS_WAIT)  state_nxt = ST_RWAIT;
                else                state_nxt = ST_RDATA;
            end
            ST_RWAIT: begin
                if (wait_cnt == 3'd0) state_nxt = ST_RDATA;
            end
            ST_RDATA: begin
                read_valid = 1'b1;
                beat_inc   = 1'b1;
                if (beat == cap_last) state_nxt = ST_IDLE;
            end
            ST_WDATA: begin
                if (write_valid) begin
                    mem_we   = 1'b1;
                    beat_inc = 1'b1;
                    if (beat == cap_last) state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                error     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            beat      <= 2'd0;
            wait_cnt  <= 3'd0;
            cap_read  <= 1'b0;
            cap_legal <= 1'b0;
            cap_idx   <= '0;
            cap_last  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && (read | write)) begin
                cap_read  <= read;
                cap_legal <= req_legal;
                cap_idx   <= word_off[IDX_W-1:0];
                cap_last  <= 2'(req_beats - 3'd1);
            end
            if (state == ST_GRANT)  beat <= 2'd0;
            else if (beat_inc)      beat <= beat + 2'd1;
            if (state == ST_GRANT)  wait_cnt <= 3'(RD_WAIT - 1);
            else if (state == ST_RWAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        end
    end

    assign mem_idx   = cap_idx + IDX_W'(beat);
    assign read_data = read_valid ? mem_rdata : 64'h0;
    assign dbg_state = state;

    ip_codma_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (mem_idx),
        .wdata (write_data),
        .raddr (mem_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ip_codma_mem_target.sv
// Bench for ip_codma_mem_target: directed and randomized requests against an
// array-based reference model, with a queue-driven response monitor.
module tb_ip_codma_mem_target;
    import ip_codma_pkg::*;

    localparam int          DEPTH   = 256;
    localparam logic [31:0] BASE    = 32'h0000_0100;
    localparam int          RD_WAIT = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              read, write;
    logic [31:0]       addr;
    logic [3:0]        size;
    logic              grant;
    logic [63:0]       read_data;
    logic              read_valid;
    logic [63:0]       write_data;
    logic              write_valid;
    logic              error;
    mem_target_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // bit 64 set = error response expected, else read beat with data [63:0]
    logic [64:0] exp_q[$];
    logic [63:0] model_mem [DEPTH];
    logic [64:0] mon_e;

    ip_codma_mem_target #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .RD_WAIT   (RD_WAIT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .read        (read),
        .write       (write),
        .addr        (addr),
        .size        (size),
        .grant       (grant),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .write_data  (write_data),
        .write_valid (write_valid),
        .error       (error),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    function automatic void check(input bit cond, input string name,
                                  input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic int model_beats(input logic [3:0] sz);
        case (sz)
            4'd1: return 1;
            4'd2: return 2;
            4'd4: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr,
                                       input logic [31:0] a, input logic [3:0] sz);
        longint la, lb;
        int nb;
        la = longint'({32'h0, a});
        lb = longint'({32'h0, BASE});
        nb = model_beats(sz);
        if (rd == wr) return 1'b0;
        if (nb == 0) return 1'b0;
        if (la % 8 != 0) return 1'b0;
        if (la < lb) return 1'b0;
        return ((la - lb) / 8 + nb) <= DEPTH;
    endfunction

    // Monitor: every output event consumes exactly one expected entry.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1) begin
                if (read_valid || error) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_out", {62'b0, error, read_valid}, 64'h0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e[64])
                            check(error && !read_valid, "err_resp",
                                  {62'b0, error, read_valid}, 64'h2);
                        else
                            check(!error && read_valid && read_data == mon_e[63:0],
                                  "read_data", read_data, mon_e[63:0]);
                    end
                end else begin
                    check(read_data == 64'h0, "idle_data", read_data, 64'h0);
                end
            end
        end
    end

    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [3:0] sz, input bit fixed_data,
                          input logic [63:0] d0, input int gap);
        bit          ok, got;
        int          nb, idx, lat, first, last, cnt, g;
        logic [63:0] d;
        nb  = model_beats(sz);
        ok  = model_legal(rd, wr, a, sz);
        idx = 0;
        if (ok) idx = int'((longint'({32'h0, a}) - longint'({32'h0, BASE})) / 8);
        if (!ok) exp_q.push_back({1'b1, 64'h0});
        else if (rd) for (int i = 0; i < nb; i++) exp_q.push_back({1'b0, model_mem[idx + i]});

        @(negedge clock);
        write_valid = 1'b0;
        read = rd; write = wr; addr = a; size = sz;
        got = 1'b0; lat = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clock);
            if (grant) begin got = 1'b1; lat = c; end
        end
        check(got && lat == 0, "grant_lat", 64'(lat), 64'h0);
        read = 1'b0; write = 1'b0;
        addr = $urandom; size = 4'($urandom_range(0, 15));
        if (!got) return;

        if (!ok) begin
            if (wr) begin write_valid = 1'b1; write_data = {$urandom, $urandom}; end
            @(negedge clock);
            check(error == 1'b1, "err_lat", {63'b0, error}, 64'h1);
        end else if (rd) begin
            first = -1; last = -1; cnt = 0;
            for (int c = 1; c <= RD_WAIT + nb + 2; c++) begin
                @(negedge clock);
                if (read_valid) begin
                    if (first < 0) first = c;
                    last = c;
                    cnt++;
                end
            end
            check(first == RD_WAIT + 1, "rd_first_lat", 64'(first), 64'(RD_WAIT + 1));
            check(cnt == nb && last - first == nb - 1, "rd_burst", 64'(cnt), 64'(nb));
        end else begin
            write_valid = 1'($urandom_range(0, 1));
            write_data  = {$urandom, $urandom};
            for (int i = 0; i < nb; i++) begin
                if (i == 0) g = (gap < 0) ? int'($urandom_range(0, 1)) : 0;
                else        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) begin
                    @(negedge clock);
                    write_valid = 1'b0;
                    write_data  = {$urandom, $urandom};
                end
                @(negedge clock);
                d = fixed_data ? d0 + 64'(i) : {$urandom, $urandom};
                write_valid = 1'b1;
                write_data  = d;
                model_mem[idx + i] = d;
            end
            @(negedge clock);
            write_valid = 1'b0;
            check(dbg_state == ST_IDLE, "wr_done", 64'(dbg_state), 64'(ST_IDLE));
        end
    endtask

    initial begin
        int          cnt, k;
        bit          rd, wr;
        logic [31:0] a;
        logic [3:0]  sz;

        reset_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; size = '0;
        write_data = '0; write_valid = 1'b0;
        repeat (3) @(negedge clock);
        check({grant, read_valid, error} == 3'b000, "reset_ctrl",
              {61'b0, grant, read_valid, error}, 64'h0);
        check(read_data == 64'h0, "reset_data", read_data, 64'h0);
        check(dbg_state == ST_IDLE, "reset_state", 64'(dbg_state), 64'(ST_IDLE));
        reset_n = 1'b1;

        for (int w = 0; w < DEPTH; w += 4)
            do_txn(1'b0, 1'b1, BASE + 32'(w * 8), 4'd4, 1'b0, 64'h0, -1);

        do_txn(1'b0, 1'b1, BASE + 32'h10, 4'd4, 1'b1, 64'hA0, 0);
        do_txn(1'b1, 1'b0, BASE + 32'h10, 4'd4, 1'b0, 64'h0, 0);
        do_txn(1'b0, 1'b1, BASE + 32'h08, 4'd2, 1'b1, 64'hB0, 1);
        do_txn(1'b1, 1'b0, BASE + 32'h10, 4'd1, 1'b0, 64'h0, 0);

        do_txn(1'b1, 1'b0, BASE + 32'h04, 4'd1, 1'b0, 64'h0, 0);
        do_txn(1'b1, 1'b0, BASE + 32'h10, 4'd3, 1'b0, 64'h0, 0);
        do_txn(1'b1, 1'b1, BASE + 32'h10, 4'd1, 1'b0, 64'h0, 0);
        do_txn(1'b0, 1'b1, BASE + 32'(DEPTH * 8 - 8), 4'd2, 1'b0, 64'h0, 0);
        do_txn(1'b1, 1'b0, 32'hFFFF_FFF8, 4'd4, 1'b0, 64'h0, 0);
        do_txn(1'b1, 1'b0, BASE - 32'h8, 4'd1, 1'b0, 64'h0, 0);
        do_txn(1'b1, 1'b0, BASE + 32'(DEPTH * 8 - 16), 4'd2, 1'b0, 64'h0, 0);
        do_txn(1'b1, 1'b0, BASE + 32'h08, 4'd4, 1'b0, 64'h0, 0);

        // Reset in the middle of a 4-beat read.
        do_txn(1'b0, 1'b1, BASE + 32'h10, 4'd4, 1'b1, 64'hC0, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, model_mem[2 + i]});
        @(negedge clock);
        read = 1'b1; addr = BASE + 32'h10; size = 4'd4;
        @(negedge clock);
        check(grant == 1'b1, "rst_grant", {63'b0, grant}, 64'h1);
        read = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12 && cnt < 2; c++) begin
            @(negedge clock);
            if (read_valid) cnt++;
        end
        check(cnt == 2, "rst_beats", 64'(cnt), 64'h2);
        #1 reset_n = 1'b0;
        @(negedge clock);
        check({grant, read_valid, error} == 3'b000, "rst_ctrl",
              {61'b0, grant, read_valid, error}, 64'h0);
        check(read_data == 64'h0, "rst_data", read_data, 64'h0);
        check(dbg_state == ST_IDLE, "rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check(exp_q.size() == 2, "rst_flush", 64'(exp_q.size()), 64'h2);
        exp_q.delete();
        reset_n = 1'b1;
        do_txn(1'b1, 1'b0, BASE + 32'h10, 4'd1, 1'b0, 64'h0, 0);
        do_txn(1'b1, 1'b0, BASE + 32'h10, 4'd4, 1'b0, 64'h0, 0);

        for (int n = 0; n < 200; n++) begin
            k = int'($urandom_range(0, 19));
            rd = (k < 9) || (k >= 18);
            wr = (k >= 9);
            k = int'($urandom_range(0, 9));
            if (k <= 6)      a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd8;
            else if (k == 7) a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd8
                                 + 32'($urandom_range(1, 7));
            else if (k == 8) a = 32'($urandom_range(0, 31)) * 32'd8;
            else             a = $urandom & 32'hFFFF_FFF8;
            k = int'($urandom_range(0, 9));
            if (k < 3)      sz = 4'd1;
            else if (k < 6) sz = 4'd2;
            else if (k < 9) sz = 4'd4;
            else            sz = 4'($urandom_range(0, 15));
            do_txn(rd, wr, a, sz, 1'b0, 64'h0, -1);
        end

        write_valid = 1'b0;
        repeat (6) @(negedge clock);
        check(exp_q.size() == 0, "queue_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
